ram_frame_reader: RTL

//  Reads the 160x120 8-bit frame buffer RAM, after it has been filled, back out as a pixel stream.

---
 rtl/ram_frame_reader_if.sv | 32 +++
 rtl/ram_frame_reader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ram_frame_reader_if.sv
// Bundles the frame reader's control, RAM read port and pixel stream signals.
// master = the reader itself, slave = whatever drives the RAM, start and pix_ready.
interface ram_frame_reader_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] ram_rdaddr;
   logic              ram_rden;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic [7:0]        pix_x;
   logic [6:0]        pix_y;
   logic              pix_sof;
   logic              pix_eol;
   logic              busy;
   logic              done;

   modport master (
      input  start, ram_q, pix_ready,
      output ram_rdaddr, ram_rden, pix_data, pix_valid, pix_x, pix_y,
             pix_sof, pix_eol, busy, done
   );

   modport slave (
      output start, ram_q, pix_ready,
      input  ram_rdaddr, ram_rden, pix_data, pix_valid, pix_x, pix_y,
             pix_sof, pix_eol, busy, done
   );
endinterface

// File: rtl/ram_frame_reader.sv
// Streams a WIDTH x HEIGHT frame out of a 1-cycle-latency RAM in raster order.
// Optional macro FRAME_READER_LOOP_EN: read frames back-to-back forever instead of once per start.
module ram_frame_reader #(
   parameter int WIDTH     = 160,
   parameter int HEIGHT    = 120,
   parameter int ADDR_W    = 19,
   parameter int DATA_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input logic                clk,
   input logic                reset,
   ram_frame_reader_if.master bus
);
   localparam int PIXELS = WIDTH * HEIGHT;
   localparam int CNT_W  = $clog2(PIXELS);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  rd_cnt;
   logic [7:0]        rd_x;
   logic [6:0]        rd_y;
   logic              done_r;

   logic              inflight;
   logic [7:0]        inflight_x;
   logic [6:0]        inflight_y;

   logic [DATA_W-1:0] buf_data [2];
   logic [7:0]        buf_x    [2];
   logic [6:0]        buf_y    [2];
   logic              buf_sof  [2];
   logic              buf_eol  [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;

   logic              pop;
   logic              issue;
   logic              last_issue;
   logic              last_pop;
   logic [2:0]        occ_next;

   // A slot freed by this cycle's pop may be reused, so full-rate streaming
   // needs no bubble, yet a stalled consumer never overfills the two entries.
   assign pop        = (count != 2'd0) && bus.pix_ready;
   assign occ_next   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign issue      = (state == READ) && (occ_next < 3'd2);
   assign last_issue = issue && (rd_cnt == CNT_W'(PIXELS - 1));
   assign last_pop   = pop && buf_eol[rd_ptr] && (buf_y[rd_ptr] == 7'(HEIGHT - 1));

   assign bus.ram_rden   = issue;
   assign bus.ram_rdaddr = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_cnt);
   assign bus.pix_valid  = (count != 2'd0);
   assign bus.pix_data   = buf_data[rd_ptr];
   assign bus.pix_x      = buf_x[rd_ptr];
   assign bus.pix_y      = buf_y[rd_ptr];
   assign bus.pix_sof    = buf_sof[rd_ptr];
   assign bus.pix_eol    = buf_eol[rd_ptr];
   assign bus.busy       = (state == READ) || (state == DRAIN);
   assign bus.done       = done_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         rd_cnt <= '0;
         rd_x   <= '0;
         rd_y   <= '0;
         done_r <= 1'b0;
      end else begin
`ifdef FRAME_READER_LOOP_EN
         done_r <= last_pop;
`endif
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state  <= READ;
                  rd_cnt <= '0;
                  rd_x   <= '0;
                  rd_y   <= '0;
                  done_r <= 1'b0;
               end
            end
            READ: begin
               if (last_issue) begin
                  rd_cnt <= '0;
                  rd_x   <= '0;
                  rd_y   <= '0;
`ifndef FRAME_READER_LOOP_EN
                  state  <= DRAIN;
`endif
               end else if (issue) begin
                  rd_cnt <= rd_cnt + 1'b1;
                  if (rd_x == 8'(WIDTH - 1)) begin
                     rd_x <= '0;
                     rd_y <= rd_y + 1'b1;
                  end else begin
                     rd_x <= rd_x + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (last_pop) begin
                  state  <= DONE;
                  done_r <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The pixel coordinates travel with the read so the returning RAM word is
   // tagged without recomputing position from the buffer side.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight   <= 1'b0;
         inflight_x <= '0;
         inflight_y <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            buf_data[i] <= '0;
            buf_x[i]    <= '0;
            buf_y[i]    <= '0;
            buf_sof[i]  <= 1'b0;
            buf_eol[i]  <= 1'b0;
         end
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_x <= rd_x;
            inflight_y <= rd_y;
         end
         if (inflight) begin
            buf_data[wr_ptr] <= bus.ram_q;
            buf_x[wr_ptr]    <= inflight_x;
            buf_y[wr_ptr]    <= inflight_y;
            buf_sof[wr_ptr]  <= (inflight_x == 8'd0) && (inflight_y == 7'd0);
            buf_eol[wr_ptr]  <= (inflight_x == 8'(WIDTH - 1));
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, inflight} - {1'b0, pop};
      end
   end
endmodule
